// File: rtl/permutation_fsm_pkg.sv
// ascon_pack: round-control constants and FSM state type shared by the permutation control block.
package ascon_pack;
  localparam int ROUND_W = 4;
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(11);
  localparam logic [ROUND_W-1:0] P6_FIRST = ROUND_W'(6);
  typedef enum logic [1:0] {IDLE, RUN, DONE} type_perm_fsm_state;
endpackage

// File: rtl/permutation_fsm_compteur_ronde.sv
// compteur_ronde: loadable round up-counter; load has priority over increment.
module compteur_ronde
  import ascon_pack::*;
(
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [ROUND_W-1:0] load_val_i,
  input  logic               inc_i,
  output logic [ROUND_W-1:0] count_o
);
  logic [ROUND_W-1:0] count_q, count_d;
  always_comb count_d = load_i ? load_val_i : inc_i ? count_q + ROUND_W'(1) : count_q;
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) count_q <= '0;
    else count_q <= count_d;
  assign count_o = count_q;
endmodule

// File: rtl/permutation_fsm.sv
// permutation_fsm: sequences p12/p6 rounds for the ASCON core and pulses done when the state is permuted.
module permutation_fsm
  import ascon_pack::*;
(
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               p6_i,
  output logic [ROUND_W-1:0] round_o,
  output logic               enable_o,
  output logic               sel_mux_o,
  output logic               busy_o,
  output logic               done_o
);
  type_perm_fsm_state state_q, state_d;
  logic first_q, first_d, is_idle, is_run, is_done, last, go, load, inc;
  logic [ROUND_W-1:0] load_val;
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      state_q <= IDLE;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  always_comb begin
    is_idle  = state_q == IDLE;
    is_run   = state_q == RUN;
    is_done  = state_q == DONE;
    last     = round_o == LAST_ROUND;
    go       = is_idle && start_i;
    state_d  = go ? RUN : (is_run && !last) ? RUN : (is_run && last) ? DONE : IDLE;
    first_d  = go;
    // counter returns to 0 on the last round so IDLE always shows round 0
    load     = go || (is_run && last);
    load_val = (go && p6_i) ? P6_FIRST : '0;
    inc      = is_run && !last;
  end
  compteur_ronde u_cnt (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .load_i     (load),
    .load_val_i (load_val),
    .inc_i      (inc),
    .count_o    (round_o)
  );
  assign enable_o  = is_run;
  assign sel_mux_o = (is_run && !first_q) || is_done;
  assign busy_o    = !is_idle;
  assign done_o    = is_done;
endmodule
